// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: run-mode encoding and direction constants shared by the programmable counter.
package prog_counter_pkg;
  typedef enum logic [1:0] {MODE_WRAP, MODE_ONESHOT, MODE_PINGPONG, MODE_RSVD} cnt_mode_e;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/prog_counter_next.sv
// prog_counter_next: combinational step function giving next count, next direction and one-shot completion.
module prog_counter_next
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] term,
  input  cnt_mode_e        mode,
  input  logic             dir,
  input  logic             cur_dir,
  input  logic             done,
  output logic [WIDTH-1:0] nxt_count,
  output logic             nxt_dir,
  output logic             hit
);
  logic pp, os, eff, over, at_end;
  logic [WIDTH-1:0] end_val, wrap_nxt, pp_nxt;
  always_comb begin
    pp = mode == MODE_PINGPONG;
    os = mode == MODE_ONESHOT;
    eff = pp ? cur_dir : dir;
    end_val = eff ? term : '0;
    over = count > term;
    at_end = count == end_val;
    wrap_nxt = eff ? ((at_end || over) ? '0 : count + 1'b1)
                   : ((at_end || over) ? term : count - 1'b1);
    // a zero terminal pins ping-pong at 0 while the direction keeps toggling
    pp_nxt = over ? term
           : at_end ? ((term == '0) ? '0 : (eff ? count - 1'b1 : count + 1'b1))
           : (eff ? count + 1'b1 : count - 1'b1);
    nxt_count = pp ? pp_nxt : (os && (done || at_end)) ? count : wrap_nxt;
    nxt_dir = pp ? (over ? DIR_DOWN : at_end ? ~cur_dir : cur_dir) : dir;
    hit = os && !done && (at_end || wrap_nxt == end_val);
  end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: programmable-terminal up/down counter with wrap, one-shot and ping-pong modes.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEFAULT_TERM = 71
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             term_wr,
  input  logic [WIDTH-1:0] term_val,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done,
  output logic             cur_dir
);
  logic [WIDTH-1:0] term_reg, nxt_count;
  logic nxt_dir, hit;
  cnt_mode_e m;
  assign m = cnt_mode_e'(mode);
  prog_counter_next #(.WIDTH(WIDTH)) u_next (
    .count(count),
    .term(term_reg),
    .mode(m),
    .dir(dir),
    .cur_dir(cur_dir),
    .done(done),
    .nxt_count(nxt_count),
    .nxt_dir(nxt_dir),
    .hit(hit)
  );
  // a finished one-shot never reports another terminal count
  assign tc = en && !(done && m == MODE_ONESHOT) &&
              count == (((m == MODE_PINGPONG) ? cur_dir : dir) ? term_reg : '0);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      term_reg <= WIDTH'(DEFAULT_TERM);
      done <= 1'b0;
      cur_dir <= DIR_UP;
    end else begin
      if (term_wr) term_reg <= term_val;
      if (clr) begin
        count <= '0;
        done <= 1'b0;
        cur_dir <= DIR_UP;
      end else if (load) begin
        count <= load_val;
        done <= 1'b0;
      end else if (en) begin
        count <= nxt_count;
        cur_dir <= nxt_dir;
        done <= done | hit;
      end
    end
  end
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: scoreboard bench; stimulus queues expected post-edge state, a monitor compares it.
module tb_prog_counter;
  logic clk = 1'b0;
  logic resetn, en, clr, load, term_wr, dir;
  logic [7:0] load_val, term_val, count;
  logic [1:0] mode;
  logic tc, done, cur_dir;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0] c;
    logic t;
    logic d;
    logic cd;
    string n;
  } exp_t;
  exp_t q[$];
  exp_t e;
  prog_counter #(.WIDTH(8), .DEFAULT_TERM(71)) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .clr(clr),
    .load(load),
    .load_val(load_val),
    .term_wr(term_wr),
    .term_val(term_val),
    .dir(dir),
    .mode(mode),
    .count(count),
    .tc(tc),
    .done(done),
    .cur_dir(cur_dir)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick(input logic [7:0] c, input logic t, input logic d, input logic cd, input string n);
    q.push_back('{c, t, d, cd, n});
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.n, " count"}, 32'(count), 32'(e.c));
      chk({e.n, " tc"}, 32'(tc), 32'(e.t));
      chk({e.n, " done"}, 32'(done), 32'(e.d));
      chk({e.n, " cur_dir"}, 32'(cur_dir), 32'(e.cd));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue depth %0d expected 0", q.size());
    $fatal(1, "timeout");
  end
  initial begin
    resetn = 0; en = 0; clr = 0; load = 0; load_val = 0;
    term_wr = 0; term_val = 0; dir = 1; mode = 2'b00;
    #12;
    chk("reset count", 32'(count), 0);
    chk("reset done", 32'(done), 0);
    chk("reset cur_dir", 32'(cur_dir), 1);
    en = 1;
    #1;
    chk("reset tc", 32'(tc), 0);
    @(negedge clk);
    resetn = 1;
    for (int k = 1; k <= 112; k++) tick(8'(k % 72), (k % 72) == 71, 0, 1, "wrap_up");
    #2 resetn = 0;
    #1;
    chk("async reset count", 32'(count), 0);
    chk("async reset cur_dir", 32'(cur_dir), 1);
    @(negedge clk);
    resetn = 1;
    term_wr = 1; term_val = 5; load = 1; load_val = 2; dir = 0;
    tick(2, 0, 0, 1, "load_down");
    term_wr = 0; load = 0;
    tick(1, 0, 0, 0, "wrap_down");
    tick(0, 1, 0, 0, "wrap_down");
    tick(5, 0, 0, 0, "wrap_down");
    tick(4, 0, 0, 0, "wrap_down");
    en = 0;
    repeat (3) tick(4, 0, 0, 0, "en_hold");
    en = 1;
    tick(3, 0, 0, 0, "wrap_down");
    tick(2, 0, 0, 0, "wrap_down");
    tick(1, 0, 0, 0, "wrap_down");
    tick(0, 1, 0, 0, "wrap_down");
    clr = 1; term_wr = 1; term_val = 3; mode = 2'b01; dir = 1;
    tick(0, 0, 0, 1, "oneshot_clr");
    clr = 0; term_wr = 0;
    tick(1, 0, 0, 1, "oneshot");
    tick(2, 0, 0, 1, "oneshot");
    tick(3, 0, 1, 1, "oneshot_end");
    tick(3, 0, 1, 1, "oneshot_hold");
    tick(3, 0, 1, 1, "oneshot_hold");
    load = 1; load_val = 1;
    tick(1, 0, 0, 1, "oneshot_load");
    load = 0;
    tick(2, 0, 0, 1, "oneshot");
    tick(3, 0, 1, 1, "oneshot_end2");
    clr = 1; mode = 2'b10;
    tick(0, 0, 0, 1, "pp_clr");
    clr = 0;
    tick(1, 0, 0, 1, "pp");
    tick(2, 0, 0, 1, "pp");
    tick(3, 1, 0, 1, "pp_top");
    tick(2, 0, 0, 0, "pp");
    tick(1, 0, 0, 0, "pp");
    tick(0, 1, 0, 0, "pp_bottom");
    tick(1, 0, 0, 1, "pp");
    tick(2, 0, 0, 1, "pp");
    mode = 2'b00; dir = 1; load = 1; load_val = 10; term_wr = 1; term_val = 6;
    tick(10, 0, 0, 1, "over_setup");
    load = 0; term_wr = 0;
    tick(0, 0, 0, 1, "over_wrap");
    tick(1, 0, 0, 1, "over_wrap");
    mode = 2'b10; load = 1; load_val = 10;
    tick(10, 0, 0, 1, "over_pp_setup");
    load = 0;
    tick(6, 0, 0, 0, "over_pp");
    tick(5, 0, 0, 0, "over_pp");
    clr = 1; load = 1; load_val = 9; term_wr = 1; term_val = 12;
    tick(0, 0, 0, 1, "all_at_once");
    clr = 0; load = 0; term_wr = 0; mode = 2'b00; dir = 1;
    tick(1, 0, 0, 1, "new_term");
    load = 1; load_val = 11;
    tick(11, 0, 0, 1, "new_term");
    load = 0;
    tick(12, 1, 0, 1, "new_term_tc");
    tick(0, 0, 0, 1, "new_term_wrap");
    repeat (2) @(negedge clk);
    chk("queue drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the fixed-terminal binary counter.
- Separates counter WIDTH from terminal value; terminal value is runtime-programmable.
- Adds enable, synchronous clear, parallel load, up/down direction, and three run modes: wrap, one-shot and ping-pong.
- Used as the protocol block's programmable timebase, bit/word counter and timeout generator.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- DEFAULT_TERM, 71, terminal value loaded into the shadow register at reset; must satisfy DEFAULT_TERM < 2**WIDTH.

Ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- en  in  1  count enable; a step occurs only on cycles with en=1.
- clr  in  1  synchronous clear.
- load  in  1  synchronous parallel load of load_val.
- load_val  in  WIDTH  value for load.
- term_wr  in  1  write term_val into the shadow terminal register.
- term_val  in  WIDTH  new terminal value.
- dir  in  1  1=up, 0=down; used in WRAP and ONESHOT only.
- mode  in  2  00=WRAP, 01=ONESHOT, 10=PINGPONG, 11=reserved (behaves as WRAP).
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count strobe, combinational: en && (count == end value).
- done  out  1  ONESHOT finished flag, registered, sticky.
- cur_dir  out  1  effective direction, registered; for PINGPONG observability.

Behaviour:
- Reset (resetn=0, async):
  - count=0, term_reg=DEFAULT_TERM, done=0, cur_dir=1.
  - tc=0, because count=0 is not an up end value unless term_reg=0; tc is still gated by en.
- Priority per cycle: clr > load > step.
  - term_wr is independent and takes effect from the next cycle.
- clr: count=0, done=0, cur_dir=1.
- load: count=load_val, done=0.
  - cur_dir unchanged.
  - load_val > term_reg is legal; see the overshoot rule below.
- End value: up direction = term_reg; down direction = 0.
- Effective direction = dir in WRAP/ONESHOT, cur_dir in PINGPONG. In WRAP/ONESHOT, cur_dir follows dir each cycle.
- WRAP, step:
  - Up: count==term_reg -> 0; count>term_reg (overshoot) -> 0; else +1.
  - Down: count==0 -> term_reg; count>term_reg -> term_reg; else -1.
- ONESHOT, step:
  - Move toward the end value as in WRAP.
  - On reaching the end value, hold count and set done=1 on the same edge that count becomes the end value.
  - With done=1: count holds, tc stays 0 regardless of en.
  - done clears only on clr, load or reset.
  - Changing mode does not clear done.
- PINGPONG, step:
  - cur_dir=1: count==term_reg -> count-1 and cur_dir=0 (term_reg=0 -> count stays 0, cur_dir toggles).
  - cur_dir=0: count==0 -> count+1 and cur_dir=1.
  - Sequence for term_reg=3: 0,1,2,3,2,1,0,1...
  - tc pulses at both 0 and term_reg.
  - Overshoot: count>term_reg -> count=term_reg, cur_dir=0.
- en=0: count, done and cur_dir hold; tc=0.
- Width rule: all arithmetic is modulo 2**WIDTH, but overshoot handling means count never passes term_reg by stepping.
- term_wr mid-run:
  - The new terminal applies to the comparison on the following cycle.
  - Lowering it below count triggers overshoot handling on the next step.
- Mode change mid-run takes effect on the next step; count is not reset.
- Reset asserted mid-count: all state returns to reset values immediately, with no clock needed.

Decomposition:
- Package prog_counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e {MODE_WRAP, MODE_ONESHOT, MODE_PINGPONG, MODE_RSVD};
  - localparams DIR_UP=1'b1, DIR_DOWN=1'b0.
- One natural sub-module: prog_counter_next, a combinational next-state/next-direction function of (count, term_reg, mode, dir, cur_dir, done).
- The top level holds the registers, priority logic and tc/done outputs.

Test Plan:
- Reset, WRAP, dir=1, en=1, DEFAULT_TERM=71:
  - count runs 0..71 then 0; tc high exactly in the cycle count==71; 72-cycle period.
  - Assert resetn=0 mid-run at count=40 -> count=0 asynchronously.
- term_wr term_val=5, WRAP, dir=0, load load_val=2:
  - count 2,1,0,5,4,...; tc when count==0 only.
  - en=0 for 3 cycles at count=4 -> holds 4, tc=0.
- ONESHOT, dir=1, term=3, from clr:
  - count 0,1,2,3; done=1 on the edge count becomes 3; count holds 3, tc=0 thereafter.
  - load load_val=1 -> done=0, counts 1,2,3, done=1 again.
- PINGPONG, term=3:
  - sequence 0,1,2,3,2,1,0,1; cur_dir toggles at 3 and 0; tc at each 0 and 3.
- Overshoot: WRAP up, count=10, term_wr term_val=6 -> next step count=0.
  - Same case in PINGPONG -> count=6, cur_dir=0.
- Simultaneous clr+load+en+term_wr (load_val=9, term_val=12):
  - count=0, done=0, cur_dir=1; term_reg=12 next cycle; load ignored.
